// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word read per instruction, holds the
// returned word on EXEC until the control unit consumes it, and redirects
// on taken branches.
module fetch_unit #(
    parameter int unsigned     WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             STALL,
    input  logic             BR_TAKEN,
    input  logic [WIDTH-1:0] BR_TARGET,
    output logic             MEM_REQ,
    output logic [WIDTH-1:0] MEM_ADDR,
    input  logic             MEM_ACK,
    input  logic [WIDTH-1:0] MEM_RDATA,
    output logic [WIDTH-1:0] EXEC,
    output logic             EXEC_VALID,
    output logic [WIDTH-1:0] PC_OUT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] exec_q, exec_d;
    logic [WIDTH-1:0] pc_out_q, pc_out_d;
    logic             exec_valid_q, exec_valid_d;
    logic             mem_req_q, mem_req_d;

    // State register.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset wins over any coincident ack or redirect.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pc_q         <= RESET_PC;
            exec_q       <= '0;
            pc_out_q     <= '0;
            exec_valid_q <= 1'b0;
            mem_req_q    <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            exec_q       <= exec_d;
            pc_out_q     <= pc_out_d;
            exec_valid_q <= exec_valid_d;
            mem_req_q    <= mem_req_d;
        end
    end

    // Next-state and datapath updates; a taken branch overrides everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        exec_d       = exec_q;
        pc_out_d     = pc_out_q;
        exec_valid_d = exec_valid_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (MEM_ACK) begin
                    exec_d       = MEM_RDATA;
                    pc_out_d     = pc_q;
                    pc_d         = pc_q + WIDTH'(1);
                    exec_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!STALL) begin
                    exec_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            default: begin
                state_d      = S_IDLE;
                exec_valid_d = 1'b0;
            end
        endcase

        // Redirect discards any returning data and any held instruction.
        if (BR_TAKEN) begin
            pc_d         = BR_TARGET;
            exec_d       = exec_q;
            pc_out_d     = pc_out_q;
            exec_valid_d = 1'b0;
            state_d      = S_REQ;
        end
    end

    // Request is registered alongside the state so it is high exactly in REQ.
    always_comb begin
        mem_req_d = (state_d == S_REQ);
    end

    assign MEM_REQ    = mem_req_q;
    assign MEM_ADDR   = pc_q;
    assign EXEC       = exec_q;
    assign EXEC_VALID = exec_valid_q;
    assign PC_OUT     = pc_out_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-accurate vector table, a randomized
// memory/stall stream with a scoreboard, and a zero-wait throughput run.
module tb_fetch_unit;

    logic        CLOCK;
    logic        RESET;
    logic        STALL;
    logic        BR_TAKEN;
    logic [15:0] BR_TARGET;
    logic        MEM_REQ;
    logic [15:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [15:0] MEM_RDATA;
    logic [15:0] EXEC;
    logic        EXEC_VALID;
    logic [15:0] PC_OUT;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .STALL     (STALL),
        .BR_TAKEN  (BR_TAKEN),
        .BR_TARGET (BR_TARGET),
        .MEM_REQ   (MEM_REQ),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_ACK   (MEM_ACK),
        .MEM_RDATA (MEM_RDATA),
        .EXEC      (EXEC),
        .EXEC_VALID(EXEC_VALID),
        .PC_OUT    (PC_OUT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        ack;
        logic [15:0] rdata;
        logic        e_req;
        logic [15:0] e_addr;
        logic [15:0] e_exec;
        logic        e_valid;
        logic [15:0] e_pc;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [15:0] pc;
    } sb_t;

    localparam int unsigned NVEC = 24;
    vec_t tbl [NVEC];
    sb_t  sbq [$];

    function automatic vec_t mk(logic rst, logic stall, logic br, logic [15:0] tgt,
                                logic ack, logic [15:0] rdata, logic e_req,
                                logic [15:0] e_addr, logic [15:0] e_exec,
                                logic e_valid, logic [15:0] e_pc);
        vec_t v;
        v.rst = rst; v.stall = stall; v.br = br; v.tgt = tgt;
        v.ack = ack; v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr;
        v.e_exec = e_exec; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic br,
                         input logic [15:0] tgt, input logic ack, input logic [15:0] rdata);
        RESET = rst; STALL = stall; BR_TAKEN = br; BR_TARGET = tgt;
        MEM_ACK = ack; MEM_RDATA = rdata;
    endtask

    // One clock with the given inputs, returning after outputs settle.
    task automatic cyc(input logic rst, input logic stall, input logic br,
                       input logic [15:0] tgt, input logic ack, input logic [15:0] rdata);
        @(negedge CLOCK);
        drive(rst, stall, br, tgt, ack, rdata);
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        logic [15:0] exp_addr;
        int          wait_cnt;
        int          delivered;
        int          acks;
        logic        acked;
        sb_t         e;

        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);

        //            rst stall br tgt      ack rdata     req addr     exec     vld pc_out
        tbl[0]  = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        tbl[1]  = mk(1, 1, 1, 16'h0055, 1, 16'hDEAD, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        tbl[2]  = mk(0, 0, 0, 16'h0000, 1, 16'hBEEF, 1, 16'h0000, 16'h0000, 0, 16'h0000);
        tbl[3]  = mk(0, 0, 0, 16'h0000, 1, 16'hC120, 0, 16'h0001, 16'hC120, 1, 16'h0000);
        tbl[4]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001, 16'hC120, 0, 16'h0000);
        tbl[5]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001, 16'hC120, 0, 16'h0000);
        tbl[6]  = mk(0, 0, 0, 16'h0000, 1, 16'h1234, 0, 16'h0002, 16'h1234, 1, 16'h0001);
        tbl[7]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 16'h1234, 1, 16'h0001);
        tbl[8]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 16'h1234, 1, 16'h0001);
        tbl[9]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 16'h1234, 1, 16'h0001);
        tbl[10] = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 16'h1234, 0, 16'h0001);
        tbl[11] = mk(0, 0, 1, 16'h0040, 1, 16'hFFFF, 1, 16'h0040, 16'h1234, 0, 16'h0001);
        tbl[12] = mk(0, 0, 0, 16'h0000, 1, 16'hAAAA, 0, 16'h0041, 16'hAAAA, 1, 16'h0040);
        tbl[13] = mk(0, 1, 1, 16'h0100, 0, 16'h0000, 1, 16'h0100, 16'hAAAA, 0, 16'h0040);
        tbl[14] = mk(0, 0, 1, 16'hFFFF, 0, 16'h0000, 1, 16'hFFFF, 16'hAAAA, 0, 16'h0040);
        tbl[15] = mk(0, 0, 0, 16'h0000, 1, 16'h5A5A, 0, 16'h0000, 16'h5A5A, 1, 16'hFFFF);
        tbl[16] = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h5A5A, 0, 16'hFFFF);
        tbl[17] = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h5A5A, 0, 16'hFFFF);
        tbl[18] = mk(1, 0, 0, 16'h0000, 1, 16'h7777, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        tbl[19] = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 16'h0000);
        tbl[20] = mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        tbl[21] = mk(0, 0, 1, 16'h0200, 0, 16'h0000, 1, 16'h0200, 16'h0000, 0, 16'h0000);
        tbl[22] = mk(0, 0, 0, 16'h0000, 1, 16'h0F0F, 0, 16'h0201, 16'h0F0F, 1, 16'h0200);
        tbl[23] = mk(0, 0, 0, 16'h0000, 1, 16'h9999, 1, 16'h0201, 16'h0F0F, 0, 16'h0200);

        for (int i = 0; i < int'(NVEC); i++) begin
            cyc(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].tgt, tbl[i].ack, tbl[i].rdata);
            chk($sformatf("vec%0d.mem_req", i),    16'(MEM_REQ),    16'(tbl[i].e_req));
            chk($sformatf("vec%0d.mem_addr", i),   MEM_ADDR,        tbl[i].e_addr);
            chk($sformatf("vec%0d.exec", i),       EXEC,            tbl[i].e_exec);
            chk($sformatf("vec%0d.exec_valid", i), 16'(EXEC_VALID), 16'(tbl[i].e_valid));
            chk($sformatf("vec%0d.pc_out", i),     PC_OUT,          tbl[i].e_pc);
        end

        // Randomized memory latency and stalls; scoreboard tracks each ack.
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        exp_addr  = 16'h0000;
        wait_cnt  = -1;
        delivered = 0;
        for (int c = 0; c < 600 && delivered < 40; c++) begin
            @(negedge CLOCK);
            drive(1'b0, ($urandom_range(0, 2) == 0), 1'b0, 16'h0, 1'b0, 16'h0);
            acked = 1'b0;
            if (MEM_REQ) begin
                chk("stream.mem_addr", MEM_ADDR, exp_addr);
                if (wait_cnt < 0) wait_cnt = int'($urandom_range(0, 2));
                if (wait_cnt == 0) begin
                    MEM_ACK   = 1'b1;
                    MEM_RDATA = 16'($urandom);
                    e.data    = MEM_RDATA;
                    e.pc      = exp_addr;
                    sbq.push_back(e);
                    exp_addr  = exp_addr + 16'd1;
                    wait_cnt  = -1;
                    acked     = 1'b1;
                end else begin
                    wait_cnt--;
                end
            end
            @(posedge CLOCK);
            #1;
            if (acked) begin
                e = sbq.pop_front();
                chk("stream.exec",       EXEC,            e.data);
                chk("stream.pc_out",     PC_OUT,          e.pc);
                chk("stream.exec_valid", 16'(EXEC_VALID), 16'd1);
                delivered++;
            end
        end
        chk("stream.delivered", 16'(delivered), 16'd40);
        chk("stream.drained",   16'(sbq.size()), 16'd0);

        // Zero-wait memory, no stall: after the IDLE cycle, 8 cycles yield 4 fetches.
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLOCK);
            drive(1'b0, 1'b0, 1'b0, 16'h0, MEM_REQ, 16'(16'hA000 + c));
            if (MEM_REQ) acks++;
            @(posedge CLOCK);
            #1;
        end
        chk("throughput.acks",   16'(acks), 16'd4);
        chk("throughput.pc_out", PC_OUT,    16'h0003);
        chk("throughput.addr",   MEM_ADDR,  16'h0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 16'h0000, word address of the first instruction fetched after reset.
REQ-002 Parameter WIDTH, 16, instruction and address width; all widths below are WIDTH.
REQ-003 CLOCK  in  1  single clock; all state changes on its rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 STALL  in  1  downstream control unit cannot accept EXEC this cycle.
REQ-006 BR_TAKEN  in  1  branch redirect request from the execute stage (B, BE, BLT, BLE, BNE resolved taken).
REQ-007 BR_TARGET  in  16  word address to fetch next when BR_TAKEN=1.
REQ-008 MEM_REQ  out  1  instruction memory read request.
REQ-009 MEM_ADDR  out  16  instruction memory word address.
REQ-010 MEM_ACK  in  1  memory read complete; MEM_RDATA valid this cycle only.
REQ-011 MEM_RDATA  in  16  instruction word returned by memory.
REQ-012 EXEC  out  16  registered instruction word presented to the control unit.
REQ-013 EXEC_VALID  out  1  EXEC holds a valid, not-yet-consumed instruction.
REQ-014 PC_OUT  out  16  word address of the instruction currently on EXEC.

Function
REQ-015 The block SHALL implement the states IDLE, REQ and HOLD, registered on CLOCK.
REQ-016 IDLE SHALL last exactly one cycle and transition unconditionally to REQ (subject to REQ-023).
REQ-017 In REQ, MEM_REQ SHALL be 1 and MEM_ADDR SHALL equal PC, both held stable until MEM_ACK or a redirect.
REQ-018 In IDLE and HOLD, MEM_REQ SHALL be 0; MEM_ADDR SHALL still equal PC.
REQ-019 On MEM_ACK in REQ without BR_TAKEN: EXEC<=MEM_RDATA, PC_OUT<=PC, PC<=PC+1, EXEC_VALID<=1, next state HOLD.
REQ-020 PC increment SHALL be modulo 2^16 (16'hFFFF+1 = 16'h0000), no flag raised.
REQ-021 In HOLD, EXEC, PC_OUT and EXEC_VALID=1 SHALL hold stable while STALL=1.
REQ-022 In HOLD with STALL=0, the instruction is consumed that cycle: EXEC_VALID<=0, next state REQ; EXEC and PC_OUT retain their values.
REQ-023 BR_TAKEN=1 SHALL take priority over every other non-reset event in any state: PC<=BR_TARGET, EXEC_VALID<=0, next state REQ.
REQ-024 BR_TAKEN coincident with MEM_ACK SHALL discard MEM_RDATA; EXEC and PC_OUT are not updated.
REQ-025 BR_TAKEN during REQ SHALL withdraw the outstanding request; the memory tolerates withdrawal, and the next cycle issues MEM_REQ at BR_TARGET.
REQ-026 BR_TAKEN in HOLD SHALL discard the held instruction regardless of STALL.
REQ-027 MEM_ACK outside REQ SHALL be ignored.
REQ-028 Throughput: one instruction per 2 cycles minimum (zero-wait memory, STALL=0); fetch-to-EXEC latency is 1 cycle after MEM_ACK.

Reset
REQ-029 RESET=1 at a rising edge SHALL force state IDLE, PC<=RESET_PC, EXEC<=16'h0000, PC_OUT<=16'h0000, EXEC_VALID<=0 and MEM_REQ=0 in the following cycle, overriding BR_TAKEN, MEM_ACK and STALL.
REQ-030 RESET asserted mid-request SHALL abandon the request; any MEM_ACK in the reset cycle SHALL be discarded.

Verification
REQ-031 Reset release, memory ACKs in the same cycle as REQ with data 16'hC120, STALL=0 -> MEM_ADDR 0x0000; EXEC=16'hC120, PC_OUT=0, EXEC_VALID=1 for 1 cycle; next request at 0x0001.
REQ-032 HOLD with STALL=1 for 3 cycles, then 0 -> EXEC stable for 4 cycles, then MEM_REQ at PC+1 on the following cycle.
REQ-033 BR_TAKEN=1, BR_TARGET=16'h0040, same cycle as MEM_ACK with 16'hFFFF -> EXEC unchanged, EXEC_VALID=0, next MEM_ADDR=0x0040.
REQ-034 PC=16'hFFFF fetched and ACKed -> PC_OUT=16'hFFFF, next MEM_ADDR=16'h0000.
REQ-035 RESET asserted while in REQ with 2-cycle memory latency -> MEM_REQ drops the next cycle, EXEC_VALID=0, fetch restarts at RESET_PC after the IDLE cycle.
